// File: rtl/btb_pkg.sv
// Shared definitions for the set-associative BTB: width helpers, entry field
// layout and flush sequencer state encodings.
package btb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

  function automatic int idx_width(input int num_sets);
    return clog2(num_sets);
  endfunction

  function automatic int tag_width(input int addr_w, input int num_sets, input int offset_w);
    return addr_w - clog2(num_sets) - offset_w;
  endfunction

  // Entry layout, LSB first: target, tag, valid.
  localparam int ENTRY_TGT_LSB = 0;

  function automatic int entry_tag_lsb(input int target_w);
    return target_w;
  endfunction

  function automatic int entry_valid_bit(input int tag_w, input int target_w);
    return tag_w + target_w;
  endfunction

  function automatic int entry_width(input int tag_w, input int target_w);
    return tag_w + target_w + 1;
  endfunction

endpackage

// File: rtl/btb_assoc_param_if.sv
// Front-end facing BTB bus: lookup, install, stall and flush signals.
// The BPU drives through master; the BTB sits on slave.
interface btb_assoc_param_if #(
  parameter int ADDR_W   = 32,
  parameter int TARGET_W = 32
);

  logic                BPU__Stall;
  logic [ADDR_W-1:0]   BTB_Read_Addr;
  logic [TARGET_W-1:0] BTB_Read_Data;
  logic                BTB_Hit;
  logic [ADDR_W-1:0]   BTB_Write_Addr;
  logic [TARGET_W-1:0] BTB_Write_Data;
  logic                BTB_Write_En;
  logic                BTB_Flush;
  logic                BTB_Busy;

  modport master (
    output BPU__Stall, BTB_Read_Addr, BTB_Write_Addr, BTB_Write_Data,
           BTB_Write_En, BTB_Flush,
    input  BTB_Read_Data, BTB_Hit, BTB_Busy
  );

  modport slave (
    input  BPU__Stall, BTB_Read_Addr, BTB_Write_Addr, BTB_Write_Data,
           BTB_Write_En, BTB_Flush,
    output BTB_Read_Data, BTB_Hit, BTB_Busy
  );

endinterface

// File: rtl/btb_plru_tree.sv
// Per-set tree-PLRU state. Heap-ordered nodes (root = 1); a bit of 0 steers
// the victim search left, 1 steers it right.
module btb_plru_tree
  import btb_pkg::*;
#(
  parameter  int NUM_WAYS = 4,
  parameter  int NUM_SETS = 128,
  localparam int IDX_W    = clog2(NUM_SETS),
  localparam int WAY_W    = clog2(NUM_WAYS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             rd_upd_en_i,
  input  logic [IDX_W-1:0] rd_set_i,
  input  logic [WAY_W-1:0] rd_way_i,
  input  logic             wr_upd_en_i,
  input  logic [IDX_W-1:0] wr_set_i,
  input  logic [WAY_W-1:0] wr_way_i,
  output logic [WAY_W-1:0] victim_way_o,
  input  logic             clr_en_i,
  input  logic [IDX_W-1:0] clr_set_i
);

  // Node n of the tree is stored at bit n-1.
  typedef logic [NUM_WAYS-2:0] row_t;

  row_t bits_q [NUM_SETS];
  row_t rd_row_d;
  row_t wr_base;
  row_t wr_row_d;

  function automatic row_t touch(input row_t row, input logic [WAY_W-1:0] way);
    row_t r;
    int   node;
    r    = row;
    node = NUM_WAYS + int'(way);
    for (int l = 0; l < WAY_W; l++) begin
      r[(node >> 1) - 1] = ~node[0];
      node = node >> 1;
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] victim(input row_t row);
    int node;
    node = 1;
    for (int l = 0; l < WAY_W; l++) node = 2 * node + int'(row[node-1]);
    return WAY_W'(node - NUM_WAYS);
  endfunction

  // The write update sees the read update of the same set, so both paths
  // survive and the write's path wins where they overlap.
  always_comb begin
    rd_row_d     = touch(bits_q[rd_set_i], rd_way_i);
    wr_base      = (rd_upd_en_i && (rd_set_i == wr_set_i)) ? rd_row_d : bits_q[wr_set_i];
    wr_row_d     = touch(wr_base, wr_way_i);
    victim_way_o = victim(bits_q[wr_set_i]);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < NUM_SETS; s++) bits_q[s] <= '0;
    end else if (clr_en_i) begin
      bits_q[clr_set_i] <= '0;
    end else begin
      if (rd_upd_en_i) bits_q[rd_set_i] <= rd_row_d;
      if (wr_upd_en_i) bits_q[wr_set_i] <= wr_row_d;
    end
  end

endmodule

// File: rtl/btb_assoc_param.sv
// N-way set-associative branch target buffer: registered-address lookup with
// one-cycle latency, resolve-stage install with in-place update, tree-PLRU.
module btb_assoc_param
  import btb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int TARGET_W = 32,
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 128,
  parameter int OFFSET_W = 2
) (
  input logic              CLK,
  input logic              RST,
  btb_assoc_param_if.slave bus
);

  localparam int IDX_W   = idx_width(NUM_SETS);
  localparam int TAG_W   = tag_width(ADDR_W, NUM_SETS, OFFSET_W);
  localparam int WAY_W   = clog2(NUM_WAYS);
  localparam int ENTRY_W = entry_width(TAG_W, TARGET_W);
  localparam int TAG_LSB = entry_tag_lsb(TARGET_W);
  localparam int VLD_BIT = entry_valid_bit(TAG_W, TARGET_W);
  localparam int CNT_W   = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_SET = CNT_W'(NUM_SETS - 1);

  typedef logic [ENTRY_W-1:0] entry_t;

  logic stall;
  assign stall = bus.BPU__Stall;

  // ---------------------------------------------------------------- flush FSM
  flush_state_e     state_q, state_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             in_flush;
  logic [IDX_W-1:0] clr_set;

  assign in_flush = (state_q == ST_FLUSH);
  assign clr_set  = flush_cnt_q[IDX_W-1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_FLUSH;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default before the case; a path that
  // leaves a variable unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      ST_FLUSH: begin
        if (bus.BTB_Flush) begin
          flush_cnt_d = '0;
        end else if (flush_cnt_q == LAST_SET) begin
          state_d     = ST_IDLE;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (bus.BTB_Flush) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  assign bus.BTB_Busy = in_flush;

  // ---------------------------------------------------------- pipeline regs
  logic [IDX_W-1:0]    rd_idx_in, wr_idx_in;
  logic [TAG_W-1:0]    rd_tag_in, wr_tag_in;
  logic [IDX_W-1:0]    rd_idx_q;
  logic [TAG_W-1:0]    rd_tag_q;
  logic                wr_en_q;
  logic [IDX_W-1:0]    wr_idx_q;
  logic [TAG_W-1:0]    wr_tag_q;
  logic [TARGET_W-1:0] wr_data_q;

  assign rd_idx_in = bus.BTB_Read_Addr[OFFSET_W +: IDX_W];
  assign rd_tag_in = bus.BTB_Read_Addr[ADDR_W-1 -: TAG_W];
  assign wr_idx_in = bus.BTB_Write_Addr[OFFSET_W +: IDX_W];
  assign wr_tag_in = bus.BTB_Write_Addr[ADDR_W-1 -: TAG_W];

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_idx_q <= '0;
      rd_tag_q <= '0;
    end else if (!stall) begin
      rd_idx_q <= rd_idx_in;
      rd_tag_q <= rd_tag_in;
    end
  end

  // Installs arriving while flushing are discarded rather than held.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_tag_q  <= '0;
      wr_data_q <= '0;
    end else if (in_flush) begin
      wr_en_q   <= 1'b0;
    end else if (!stall) begin
      wr_en_q   <= bus.BTB_Write_En;
      wr_idx_q  <= wr_idx_in;
      wr_tag_q  <= wr_tag_in;
      wr_data_q <= bus.BTB_Write_Data;
    end
  end

  // ------------------------------------------------------------ way storage
  logic                commit;
  logic [WAY_W-1:0]    wr_way;
  logic [WAY_W-1:0]    victim_way;
  logic [NUM_WAYS-1:0] wr_tag_hit;
  logic [NUM_WAYS-1:0] wr_inval;
  logic [NUM_WAYS-1:0] rd_match;
  logic [TARGET_W-1:0] rd_tgt [NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];

  assign commit = wr_en_q && !stall && !in_flush;

  // NOTE: valid bits and the tag/target arrays have no reset; the flush
  // sequencer that runs after every reset invalidates each set instead.
  always_ff @(posedge CLK) begin
    if (in_flush) begin
      valid_q[clr_set] <= '0;
    end else if (commit) begin
      valid_q[wr_idx_q][wr_way] <= 1'b1;
    end
  end

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    logic [TAG_W-1:0]    tag_mem [NUM_SETS];
    logic [TARGET_W-1:0] tgt_mem [NUM_SETS];
    entry_t              rd_entry_q;

    always_ff @(posedge CLK) begin
      if (commit && (wr_way == WAY_W'(w))) begin
        tag_mem[wr_idx_q] <= wr_tag_q;
        tgt_mem[wr_idx_q] <= wr_data_q;
      end
    end

    // Synchronous read sampled on the same edge as a commit returns old data.
    always_ff @(posedge CLK) begin
      if (RST) begin
        rd_entry_q <= '0;
      end else if (in_flush) begin
        rd_entry_q[VLD_BIT] <= 1'b0;
      end else if (!stall) begin
        rd_entry_q <= {valid_q[rd_idx_in][w], tag_mem[rd_idx_in], tgt_mem[rd_idx_in]};
      end
    end

    assign wr_tag_hit[w] = valid_q[wr_idx_q][w] && (tag_mem[wr_idx_q] == wr_tag_q);
    assign wr_inval[w]   = !valid_q[wr_idx_q][w];
    assign rd_match[w]   = rd_entry_q[VLD_BIT] && (rd_entry_q[TAG_LSB +: TAG_W] == rd_tag_q);
    assign rd_tgt[w]     = rd_entry_q[ENTRY_TGT_LSB +: TARGET_W];
  end

  // Way choice: existing tag, else lowest invalid way, else PLRU victim.
  // Descending scans let the lowest matching index win.
  always_comb begin
    wr_way = victim_way;
    for (int w = NUM_WAYS - 1; w >= 0; w--) if (wr_inval[w]) wr_way = WAY_W'(w);
    for (int w = NUM_WAYS - 1; w >= 0; w--) if (wr_tag_hit[w]) wr_way = WAY_W'(w);
  end

  // ----------------------------------------------------------------- lookup
  logic                rd_hit;
  logic [WAY_W-1:0]    rd_hit_way;
  logic [TARGET_W-1:0] rd_data;

  always_comb begin
    rd_hit_way = '0;
    rd_data    = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (rd_match[w]) begin
        rd_hit_way = WAY_W'(w);
        rd_data    = rd_tgt[w];
      end
    end
    rd_hit = (|rd_match) && !in_flush;
  end

  assign bus.BTB_Hit       = rd_hit;
  assign bus.BTB_Read_Data = rd_hit ? rd_data : '0;

  btb_plru_tree #(
    .NUM_WAYS (NUM_WAYS),
    .NUM_SETS (NUM_SETS)
  ) u_plru (
    .CLK          (CLK),
    .RST          (RST),
    .rd_upd_en_i  (rd_hit && !stall),
    .rd_set_i     (rd_idx_q),
    .rd_way_i     (rd_hit_way),
    .wr_upd_en_i  (commit),
    .wr_set_i     (wr_idx_q),
    .wr_way_i     (wr_way),
    .victim_way_o (victim_way),
    .clr_en_i     (in_flush),
    .clr_set_i    (clr_set)
  );

endmodule

// File: tb/tb_btb_assoc_param.sv
// Directed bench for btb_assoc_param at default parameters (4 ways, 128 sets);
// PCs 0x...004 map to set 1, tag = PC[31:9].
module tb_btb_assoc_param;

  localparam int          ADDR_W   = 32;
  localparam int          TARGET_W = 32;
  localparam logic [31:0] PARK     = 32'hFFFF_FFF0;

  logic CLK = 1'b0;
  logic RST;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   busy_cycles;

  btb_assoc_param_if #(.ADDR_W(ADDR_W), .TARGET_W(TARGET_W)) btb_if ();

  btb_assoc_param #(
    .ADDR_W   (ADDR_W),
    .TARGET_W (TARGET_W),
    .NUM_WAYS (4),
    .NUM_SETS (128),
    .OFFSET_W (2)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (btb_if)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_entry(input logic [31:0] pc, input logic [31:0] tgt);
    btb_if.BTB_Write_Addr = pc;
    btb_if.BTB_Write_Data = tgt;
    btb_if.BTB_Write_En   = 1'b1;
    step();
    btb_if.BTB_Write_En   = 1'b0;
    step();
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic exp_hit, input logic [31:0] exp_data);
    btb_if.BTB_Read_Addr = pc;
    step();
    check({tag, "_hit"}, btb_if.BTB_Hit, exp_hit);
    check({tag, "_data"}, btb_if.BTB_Read_Data, exp_data);
    btb_if.BTB_Read_Addr = PARK;
  endtask

  task automatic count_busy_window();
    busy_cycles = 0;
    for (int i = 0; i < 128; i++) begin
      if (btb_if.BTB_Busy) busy_cycles++;
      btb_if.BTB_Write_Addr = 32'h0000_6004;
      btb_if.BTB_Write_Data = 32'h0000_6666;
      btb_if.BTB_Write_En   = (i == 20);
      step();
    end
    btb_if.BTB_Write_En = 1'b0;
  endtask

  initial begin
    RST                   = 1'b1;
    btb_if.BPU__Stall     = 1'b0;
    btb_if.BTB_Read_Addr  = PARK;
    btb_if.BTB_Write_Addr = '0;
    btb_if.BTB_Write_Data = '0;
    btb_if.BTB_Write_En   = 1'b0;
    btb_if.BTB_Flush      = 1'b0;
    repeat (3) step();

    check("rst_hit", btb_if.BTB_Hit, 1'b0);
    check("rst_data", btb_if.BTB_Read_Data, 32'h0);
    check("rst_busy", btb_if.BTB_Busy, 1'b1);

    // Power-up flush: busy for exactly 128 cycles, then idle.
    RST         = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 128; i++) begin
      if (btb_if.BTB_Busy) busy_cycles++;
      step();
    end
    check("init_busy_cycles", busy_cycles, 128);
    check("init_busy_end", btb_if.BTB_Busy, 1'b0);

    lookup("cold", 32'h0000_1000, 1'b0, 32'h0);

    write_entry(32'h0000_1004, 32'h0000_2000);
    lookup("first_install", 32'h0000_1004, 1'b1, 32'h0000_2000);

    // In-place update: a duplicate in way 1 would leave way 0's 0x2000 visible.
    write_entry(32'h0000_1004, 32'h0000_3000);
    lookup("rewrite", 32'h0000_1004, 1'b1, 32'h0000_3000);
    write_entry(32'h0000_2004, 32'h0000_2100);
    write_entry(32'h0000_3004, 32'h0000_2200);
    write_entry(32'h0000_4004, 32'h0000_2300);
    lookup("fill_1004", 32'h0000_1004, 1'b1, 32'h0000_3000);
    lookup("fill_2004", 32'h0000_2004, 1'b1, 32'h0000_2100);
    lookup("fill_3004", 32'h0000_3004, 1'b1, 32'h0000_2200);
    lookup("fill_4004", 32'h0000_4004, 1'b1, 32'h0000_2300);

    // Stall: outputs frozen, lookup and install both held off.
    btb_if.BTB_Read_Addr = 32'h0000_2004;
    step();
    check("stall_pre_hit", btb_if.BTB_Hit, 1'b1);
    check("stall_pre_data", btb_if.BTB_Read_Data, 32'h0000_2100);
    btb_if.BPU__Stall     = 1'b1;
    btb_if.BTB_Read_Addr  = 32'h0000_3004;
    btb_if.BTB_Write_Addr = 32'h0000_5004;
    btb_if.BTB_Write_Data = 32'h0000_9999;
    btb_if.BTB_Write_En   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hit", btb_if.BTB_Hit, 1'b1);
      check("stall_data", btb_if.BTB_Read_Data, 32'h0000_2100);
    end
    btb_if.BPU__Stall    = 1'b0;
    btb_if.BTB_Write_En  = 1'b0;
    btb_if.BTB_Read_Addr = PARK;
    step();
    step();
    lookup("stall_no_install", 32'h0000_5004, 1'b0, 32'h0);

    // Highest set index, tag 0.
    write_entry(32'h0000_01FC, 32'h0000_1111);
    lookup("last_set", 32'h0000_01FC, 1'b1, 32'h0000_1111);

    // Flush pulse with a lookup and an install in the same cycle.
    btb_if.BTB_Read_Addr  = 32'h0000_1004;
    btb_if.BTB_Write_Addr = 32'h0000_7004;
    btb_if.BTB_Write_Data = 32'h0000_7777;
    btb_if.BTB_Write_En   = 1'b1;
    btb_if.BTB_Flush      = 1'b1;
    step();
    btb_if.BTB_Flush      = 1'b0;
    btb_if.BTB_Write_En   = 1'b0;
    check("flush_gate_hit", btb_if.BTB_Hit, 1'b0);
    check("flush_gate_data", btb_if.BTB_Read_Data, 32'h0);
    count_busy_window();
    check("flush_busy_cycles", busy_cycles, 128);
    check("flush_busy_end", btb_if.BTB_Busy, 1'b0);
    btb_if.BTB_Read_Addr = PARK;
    lookup("post_flush_1004", 32'h0000_1004, 1'b0, 32'h0);
    lookup("post_flush_2004", 32'h0000_2004, 1'b0, 32'h0);
    lookup("post_flush_3004", 32'h0000_3004, 1'b0, 32'h0);
    lookup("post_flush_4004", 32'h0000_4004, 1'b0, 32'h0);
    lookup("post_flush_01fc", 32'h0000_01FC, 1'b0, 32'h0);
    lookup("flush_drop_6004", 32'h0000_6004, 1'b0, 32'h0);
    lookup("flush_drop_7004", 32'h0000_7004, 1'b0, 32'h0);

    // Fresh set 1, PLRU bits clear: five installs, the fifth replaces way 0.
    write_entry(32'h0000_1004, 32'h0000_A001);
    write_entry(32'h0000_2004, 32'h0000_A002);
    write_entry(32'h0000_3004, 32'h0000_A003);
    write_entry(32'h0000_4004, 32'h0000_A004);
    write_entry(32'h0000_5004, 32'h0000_A005);
    lookup("evict_1004", 32'h0000_1004, 1'b0, 32'h0);
    lookup("evict_2004", 32'h0000_2004, 1'b1, 32'h0000_A002);
    lookup("evict_3004", 32'h0000_3004, 1'b1, 32'h0000_A003);
    lookup("evict_4004", 32'h0000_4004, 1'b1, 32'h0000_A004);
    lookup("evict_5004", 32'h0000_5004, 1'b1, 32'h0000_A005);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
